// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared constants for the CORDIC engine: arctangent table,
//            quarter-turn angle, Q1.15 gain constant and mode encodings.
//            Angles are binary: full scale 2^32 = 360 degrees.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // Quarter turn (90 degrees) in binary-angle units
    localparam logic [31:0] c_ANG_90 = 32'h4000_0000;

    // Reciprocal CORDIC gain, Q1.15 (~0.60725)
    localparam logic [15:0] c_GAIN_K = 16'h4DBA;

    // Per-sample operating mode
    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } cordic_mode_e;

    // atan(2^-idx) in binary-angle units, rounded to nearest
    function automatic logic [31:0] atan_entry(input int unsigned idx);
        logic [31:0] r_val;
        case (idx)
            0:       r_val = 32'h2000_0000;
            1:       r_val = 32'h12E4_051E;
            2:       r_val = 32'h09FB_385B;
            3:       r_val = 32'h0511_11D4;
            4:       r_val = 32'h028B_0D43;
            5:       r_val = 32'h0145_D7E1;
            6:       r_val = 32'h00A2_F61E;
            7:       r_val = 32'h0051_7C55;
            8:       r_val = 32'h0028_BE53;
            9:       r_val = 32'h0014_5F2F;
            10:      r_val = 32'h000A_2F98;
            11:      r_val = 32'h0005_17CC;
            12:      r_val = 32'h0002_8BE6;
            13:      r_val = 32'h0001_45F3;
            14:      r_val = 32'h0000_A2FA;
            15:      r_val = 32'h0000_517D;
            16:      r_val = 32'h0000_28BE;
            17:      r_val = 32'h0000_145F;
            18:      r_val = 32'h0000_0A30;
            19:      r_val = 32'h0000_0518;
            20:      r_val = 32'h0000_028C;
            21:      r_val = 32'h0000_0146;
            22:      r_val = 32'h0000_00A3;
            23:      r_val = 32'h0000_0051;
            24:      r_val = 32'h0000_0029;
            25:      r_val = 32'h0000_0014;
            26:      r_val = 32'h0000_000A;
            27:      r_val = 32'h0000_0005;
            28:      r_val = 32'h0000_0003;
            29:      r_val = 32'h0000_0001;
            30:      r_val = 32'h0000_0001;
            default: r_val = 32'h0000_0000;
        endcase
        return r_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : cordic_engine_if
// Brief    : Sample-in / result-out bundle of the CORDIC engine. The engine
//            consumes the bus through the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface cordic_engine_if #(
    parameter int XY_W = 16
);
    logic                   in_valid;
    logic                   in_mode;
    logic signed [XY_W-1:0] xin;
    logic signed [XY_W-1:0] yin;
    logic        [31:0]     zin;
    logic                   out_valid;
    logic                   out_mode;
    logic signed [XY_W+1:0] xout;
    logic signed [XY_W+1:0] yout;
    logic        [31:0]     zout;
    logic                   pipe_empty;

    modport master (
        output in_valid, in_mode, xin, yin, zin,
        input  out_valid, out_mode, xout, yout, zout, pipe_empty
    );

    modport slave (
        input  in_valid, in_mode, xin, yin, zin,
        output out_valid, out_mode, xout, yout, zout, pipe_empty
    );
endinterface
`default_nettype wire

// File: rtl/cordic_stage.sv
`default_nettype none
// ============================================================================
// Module   : cordic_stage
// Brief    : One registered CORDIC micro-rotation with shift index SHIFT.
//            Rotation mode steers z toward 0, vectoring mode steers y to 0.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W     = 18,
    parameter int SHIFT = 0
) (
    input  wire logic                clock,
    input  wire logic                reset,
    input  wire logic                i_valid,
    input  wire logic                i_mode,
    input  wire logic signed [W-1:0] i_x,
    input  wire logic signed [W-1:0] i_y,
    input  wire logic        [31:0]  i_z,
    output logic                     o_valid,
    output logic                     o_mode,
    output logic signed [W-1:0]      o_x,
    output logic signed [W-1:0]      o_y,
    output logic        [31:0]       o_z
);

    localparam logic [31:0] c_ATAN = atan_entry(SHIFT);

    logic                w_dir_pos;
    logic signed [W-1:0] w_x_sh;
    logic signed [W-1:0] w_y_sh;

    assign w_dir_pos = (i_mode == MODE_VEC) ? i_y[W-1] : ~i_z[31];
    assign w_x_sh    = i_x >>> SHIFT;
    assign w_y_sh    = i_y >>> SHIFT;

    // Apply the micro-rotation; data loads every cycle, valid/mode ride along
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_mode  <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_z     <= '0;
        end else begin
            o_valid <= i_valid;
            o_mode  <= i_mode;
            o_x     <= w_dir_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
            o_y     <= w_dir_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
            o_z     <= w_dir_pos ? (i_z - c_ATAN) : (i_z + c_ATAN);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_engine.sv
`default_nettype none
// ============================================================================
// Module   : cordic_engine
// Brief    : Fully pipelined rotation/vectoring CORDIC, one sample per clock.
//            Stage 0 pre-rotates into the convergence range, then STAGES
//            micro-rotations. Optional macro CORDIC_GAIN_COMP_EN adds one
//            register stage scaling x/y by the reciprocal gain.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int XY_W   = 16,
    parameter int STAGES = 16
) (
    input  wire logic      clock,
    input  wire logic      reset,
    cordic_engine_if.slave bus
);

    localparam int c_W = XY_W + 2;

    logic signed [c_W-1:0] w_xe;
    logic signed [c_W-1:0] w_ye;
    logic signed [c_W-1:0] w_pre_x;
    logic signed [c_W-1:0] w_pre_y;
    logic        [31:0]    w_pre_z;

    logic                  r_valid0;
    logic                  r_mode0;
    logic signed [c_W-1:0] r_x0;
    logic signed [c_W-1:0] r_y0;
    logic        [31:0]    r_z0;

    logic        [STAGES:0] w_valid;
    logic        [STAGES:0] w_mode;
    logic signed [c_W-1:0]  w_x [0:STAGES];
    logic signed [c_W-1:0]  w_y [0:STAGES];
    logic        [31:0]     w_z [0:STAGES];

    assign w_xe = {{2{bus.xin[XY_W-1]}}, bus.xin};
    assign w_ye = {{2{bus.yin[XY_W-1]}}, bus.yin};

    // Fold the input into the right half-plane so the micro-rotations converge
    always_comb begin
        w_pre_x = w_xe;
        w_pre_y = w_ye;
        w_pre_z = bus.zin;
        if (bus.in_mode == MODE_ROT) begin
            case (bus.zin[31:30])
                2'b01: begin
                    w_pre_x = -w_ye;
                    w_pre_y = w_xe;
                    w_pre_z = bus.zin - c_ANG_90;
                end
                2'b10: begin
                    w_pre_x = w_ye;
                    w_pre_y = -w_xe;
                    w_pre_z = bus.zin + c_ANG_90;
                end
                default: ;
            endcase
        end else if (bus.xin[XY_W-1]) begin
            if (!bus.yin[XY_W-1]) begin
                w_pre_x = w_ye;
                w_pre_y = -w_xe;
                w_pre_z = bus.zin + c_ANG_90;
            end else begin
                w_pre_x = -w_ye;
                w_pre_y = w_xe;
                w_pre_z = bus.zin - c_ANG_90;
            end
        end
    end

    // Stage 0 register holding the pre-rotated sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid0 <= 1'b0;
            r_mode0  <= 1'b0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_z0     <= '0;
        end else begin
            r_valid0 <= bus.in_valid;
            r_mode0  <= bus.in_mode;
            r_x0     <= w_pre_x;
            r_y0     <= w_pre_y;
            r_z0     <= w_pre_z;
        end
    end

    assign w_valid[0] = r_valid0;
    assign w_mode[0]  = r_mode0;
    assign w_x[0]     = r_x0;
    assign w_y[0]     = r_y0;
    assign w_z[0]     = r_z0;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            cordic_stage #(
                .W     (c_W),
                .SHIFT (gi)
            ) u_stage (
                .clock   (clock),
                .reset   (reset),
                .i_valid (w_valid[gi]),
                .i_mode  (w_mode[gi]),
                .i_x     (w_x[gi]),
                .i_y     (w_y[gi]),
                .i_z     (w_z[gi]),
                .o_valid (w_valid[gi+1]),
                .o_mode  (w_mode[gi+1]),
                .o_x     (w_x[gi+1]),
                .o_y     (w_y[gi+1]),
                .o_z     (w_z[gi+1])
            );
        end
    endgenerate

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [16:0] c_K    = {1'b0, c_GAIN_K};
    localparam logic signed [c_W+16:0] c_HALF = (c_W+17)'(1 << 14);

    logic signed [c_W+16:0] w_px;
    logic signed [c_W+16:0] w_py;
    logic                   r_gvalid;
    logic                   r_gmode;
    logic signed [c_W-1:0]  r_gx;
    logic signed [c_W-1:0]  r_gy;
    logic        [31:0]     r_gz;

    assign w_px = w_x[STAGES] * c_K + c_HALF;
    assign w_py = w_y[STAGES] * c_K + c_HALF;

    // Scale by 1/gain (round half-up, drop Q15 fraction); z/mode/valid delayed to match
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_gvalid <= 1'b0;
            r_gmode  <= 1'b0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_gz     <= '0;
        end else begin
            r_gvalid <= w_valid[STAGES];
            r_gmode  <= w_mode[STAGES];
            r_gx     <= c_W'(w_px >>> 15);
            r_gy     <= c_W'(w_py >>> 15);
            r_gz     <= w_z[STAGES];
        end
    end

    assign bus.out_valid  = r_gvalid;
    assign bus.out_mode   = r_gmode;
    assign bus.xout       = r_gx;
    assign bus.yout       = r_gy;
    assign bus.zout       = r_gz;
    assign bus.pipe_empty = ~(|{w_valid, r_gvalid});
`else
    assign bus.out_valid  = w_valid[STAGES];
    assign bus.out_mode   = w_mode[STAGES];
    assign bus.xout       = w_x[STAGES];
    assign bus.yout       = w_y[STAGES];
    assign bus.zout       = w_z[STAGES];
    assign bus.pipe_empty = ~(|w_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_engine
// Brief    : Self-checking bench for cordic_engine. Every driven cycle is
//            logged; outputs are compared against ideal trigonometry scaled
//            by the theoretical CORDIC gain. Honours CORDIC_GAIN_COMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_engine;

    localparam int  XY_W   = 16;
    localparam int  STAGES = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LAT    = STAGES + 2;
    localparam real KCOMP  = 19898.0 / 32768.0;
`else
    localparam int  LAT    = STAGES + 1;
    localparam real KCOMP  = 1.0;
`endif
    localparam int  HMAX   = 2048;
    localparam real PI     = 3.14159265358979323846;
    localparam longint XY_TOL  = 16;
    localparam longint ROT_ZTOL = 64'h0010_0000;
    localparam longint VEC_ZTOL = 64'h0040_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    cordic_engine_if #(.XY_W(XY_W)) bus ();

    cordic_engine #(
        .XY_W   (XY_W),
        .STAGES (STAGES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    real         gain;
    logic        h_v [HMAX];
    logic        h_m [HMAX];
    int          h_x [HMAX];
    int          h_y [HMAX];
    logic [31:0] h_z [HMAX];

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
        n_checks++;
        if ((obs - exp) <= tol && (exp - obs) <= tol) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d (tol %0d)", tag, cyc, obs, exp, tol);
    endtask

    // Ideal-math reference for the sample logged at idx
    task automatic check_result(input int idx);
        real x, y, th, ex, ey, ez;
        longint ezl;
        logic [31:0] e32;
        logic signed [31:0] zerr;
        x = h_x[idx];
        y = h_y[idx];
        if (h_m[idx]) begin
            ex  = gain * $sqrt(x * x + y * y);
            ez  = $atan2(y, x) * 4294967296.0 / (2.0 * PI);
            ezl = longint'(ez);
            e32 = h_z[idx] + ezl[31:0];
            zerr = $signed(bus.zout - e32);
            check("vec_x", longint'($signed(bus.xout)), longint'(ex), XY_TOL);
            check("vec_y", longint'($signed(bus.yout)), 0, XY_TOL);
            check("vec_zerr", longint'(zerr), 0, VEC_ZTOL);
        end else begin
            th = real'($signed(h_z[idx])) * PI / 2147483648.0;
            ex = gain * (x * $cos(th) - y * $sin(th));
            ey = gain * (x * $sin(th) + y * $cos(th));
            zerr = $signed(bus.zout);
            check("rot_x", longint'($signed(bus.xout)), longint'(ex), XY_TOL);
            check("rot_y", longint'($signed(bus.yout)), longint'(ey), XY_TOL);
            check("rot_zres", longint'(zerr), 0, ROT_ZTOL);
        end
    endtask

    task automatic check_outputs();
        int   idx;
        int   lo;
        logic ev;
        logic busy;
        idx  = cyc - LAT;
        ev   = 1'b0;
        busy = 1'b0;
        if (idx >= 0) ev = h_v[idx];
        lo = (idx < 0) ? 0 : idx;
        for (int k = lo; k < cyc; k++) busy = busy | h_v[k];
        check("out_valid", longint'(bus.out_valid), longint'(ev), 0);
        check("pipe_empty", longint'(bus.pipe_empty), longint'(!busy), 0);
        if (ev) begin
            check("out_mode", longint'(bus.out_mode), longint'(h_m[idx]), 0);
            check_result(idx);
        end
    endtask

    task automatic step(input logic v, input logic m, input int x, input int y, input logic [31:0] z);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.xin      = 16'(x);
        bus.yin      = 16'(y);
        bus.zin      = z;
        h_v[cyc] = v;
        h_m[cyc] = m;
        h_x[cyc] = x;
        h_y[cyc] = y;
        h_z[cyc] = z;
        @(posedge clock);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic rand_step(input logic force_valid);
        logic v, m;
        int   x, y;
        v = force_valid | ($urandom_range(0, 3) != 0);
        m = 1'($urandom_range(0, 1));
        x = int'($urandom_range(0, 65535)) - 32768;
        y = int'($urandom_range(0, 65535)) - 32768;
        // Tiny vectors give an ill-defined angle; keep vectoring inputs large
        while (m && ((x < 0 ? -x : x) + (y < 0 ? -y : y)) < 8192) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            y = int'($urandom_range(0, 65535)) - 32768;
        end
        step(v, m, x, y, $urandom);
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rst_async_valid", longint'(bus.out_valid), 0, 0);
        check("rst_async_empty", longint'(bus.pipe_empty), 1, 0);
        check("rst_async_xout", longint'($signed(bus.xout)), 0, 0);
        for (int k = 0; k < HMAX; k++) h_v[k] = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        logic [4:0] pat;
        pat = 5'b01101;
        gain = 1.0;
        for (int i = 0; i < STAGES; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
        gain = gain * KCOMP;

        bus.in_valid = 1'b0;
        bus.in_mode  = 1'b0;
        bus.xin      = '0;
        bus.yin      = '0;
        bus.zin      = '0;
        for (int k = 0; k < HMAX; k++) h_v[k] = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_valid", longint'(bus.out_valid), 0, 0);
        check("reset_empty", longint'(bus.pipe_empty), 1, 0);
        check("reset_mode", longint'(bus.out_mode), 0, 0);
        check("reset_xout", longint'($signed(bus.xout)), 0, 0);
        check("reset_yout", longint'($signed(bus.yout)), 0, 0);
        check("reset_zout", longint'(bus.zout), 0, 0);
        reset = 1'b0;

        // Directed vectors, including quadrant folds and the most negative input
        step(1'b1, 1'b0, 10000, 0, 32'h2000_0000);
        step(1'b1, 1'b0, 10000, 0, 32'h6000_0000);
        step(1'b1, 1'b1, 3000, 4000, 32'h0000_0000);
        step(1'b1, 1'b1, -10000, 0, 32'h0000_0000);
        step(1'b1, 1'b1, -32768, -32768, 32'h0000_0000);
        step(1'b1, 1'b0, -32768, 32767, 32'h9000_0000);
        step(1'b1, 1'b0, -32768, -32768, 32'hC000_0000);

        // Bubble pattern 1,0,1,1,0 with alternating modes
        for (int i = 0; i < 10; i++)
            step(pat[i % 5], 1'(i % 2), 12000, -5000, 32'(i) * 32'h0123_4567);

        for (int i = 0; i < 300; i++) rand_step(1'b0);

        // Drop five in-flight samples with a one-cycle reset
        for (int i = 0; i < 5; i++) rand_step(1'b1);
        mid_reset();

        for (int i = 0; i < 40; i++) rand_step(1'b0);
        for (int i = 0; i < LAT + 2; i++) step(1'b0, 1'b0, 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
